// File: rtl/fifo_wr_packer_if.sv
// Handshake/bus bundle between the word source, the packer and the TX FIFO.
// Word input, FIFO write port, overflow flag, byte counter and busy status.
interface fifo_wr_packer_if;
    logic [15:0] IN_DATA;
    logic        IN_WIDE;
    logic        IN_VALID;
    logic        IN_READY;
    logic        FIFO_FULL;
    logic [7:0]  WR_DATA;
    logic        WR_INC;
    logic        OVF_CLR;
    logic        OVERFLOW;
    logic [7:0]  BYTE_CNT;
    logic        BUSY;

    modport master (
        output IN_DATA, IN_WIDE, IN_VALID, FIFO_FULL, OVF_CLR,
        input  IN_READY, WR_DATA, WR_INC, OVERFLOW, BYTE_CNT, BUSY
    );

    modport slave (
        input  IN_DATA, IN_WIDE, IN_VALID, FIFO_FULL, OVF_CLR,
        output IN_READY, WR_DATA, WR_INC, OVERFLOW, BYTE_CNT, BUSY
    );
endinterface

// File: rtl/fifo_wr_packer.sv
// Word queue + byte serialiser feeding the async TX FIFO write port (REF_CLK).
// Ports: CLK, RST (async active-low), bus (slave side of fifo_wr_packer_if).
module fifo_wr_packer #(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic           CLK,
    input logic           RST,
    fifo_wr_packer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1
    } state_t;

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [16:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;

    state_t        state_q;
    state_t        state_d;
    logic [15:0]   word_q;
    logic [15:0]   word_d;
    logic          wide_q;
    logic          wide_d;
    logic [7:0]    wr_data_q;
    logic [7:0]    wr_data_d;
    logic          ovf_q;
    logic [7:0]    cnt_q;

    logic          in_ready;
    logic          push;
    logic          pop;
    logic          wr_inc;
    logic [16:0]   head;

    // Ready looks only at the registered count: no same-edge pop bypass.
    assign in_ready = (count_q != FULL_CNT);
    assign push     = bus.IN_VALID && in_ready;
    // Never strobe a full FIFO; the byte just waits in WR_DATA.
    assign wr_inc   = (state_q != IDLE) && !bus.FIFO_FULL;
    assign head     = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        wide_d    = wide_q;
        wr_data_d = wr_data_q;
        pop       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop       = 1'b1;
                    word_d    = head[15:0];
                    wide_d    = head[16];
                    wr_data_d = (MSB_FIRST && head[16]) ?
                                head[15:8] : head[7:0];
                    state_d   = BYTE0;
                end
            end
            BYTE0: begin
                if (wr_inc) begin
                    if (wide_q) begin
                        wr_data_d = MSB_FIRST ?
                                    word_q[7:0] : word_q[15:8];
                        state_d   = BYTE1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            BYTE1: begin
                if (wr_inc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {bus.IN_WIDE, bus.IN_DATA};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            word_q    <= '0;
            wide_q    <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            wide_q    <= wide_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Sticky overflow; a new drop on the same edge beats the clear.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            if (bus.IN_VALID && !in_ready) begin
                ovf_q <= 1'b1;
            end else if (bus.OVF_CLR) begin
                ovf_q <= 1'b0;
            end
            if (wr_inc) begin
                cnt_q <= cnt_q + 8'd1;
            end
        end
    end

    assign bus.IN_READY = in_ready;
    assign bus.WR_DATA  = wr_data_q;
    assign bus.WR_INC   = wr_inc;
    assign bus.OVERFLOW = ovf_q;
    assign bus.BYTE_CNT = cnt_q;
    assign bus.BUSY     = (count_q != '0) || (state_q != IDLE);
endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed self-checking bench for fifo_wr_packer.
// Instance a: LSB first; instance b: MSB first.
module tb_fifo_wr_packer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   incs;
    logic [7:0] got [$];
    logic [7:0] exp_b [7];
    logic [7:0] g;

    fifo_wr_packer_if ia();
    fifo_wr_packer_if ib();

    fifo_wr_packer #(.DEPTH(4), .MSB_FIRST(1'b0)) dut_a (
        .CLK(clk),
        .RST(rst_n),
        .bus(ia)
    );

    fifo_wr_packer #(.DEPTH(4), .MSB_FIRST(1'b1)) dut_b (
        .CLK(clk),
        .RST(rst_n),
        .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic w, input logic [15:0] d);
        ia.IN_VALID = 1'b1;
        ia.IN_WIDE  = w;
        ia.IN_DATA  = d;
        step();
        ia.IN_VALID = 1'b0;
    endtask

    task automatic push_b(input logic w, input logic [15:0] d);
        ib.IN_VALID = 1'b1;
        ib.IN_WIDE  = w;
        ib.IN_DATA  = d;
        step();
        ib.IN_VALID = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_b = '{8'h11, 8'h33, 8'h22, 8'h44, 8'h66, 8'h55, 8'h77};
        rst_n = 1'b0;
        ia.IN_DATA = '0; ia.IN_WIDE = 0; ia.IN_VALID = 0;
        ia.FIFO_FULL = 0; ia.OVF_CLR = 0;
        ib.IN_DATA = '0; ib.IN_WIDE = 0; ib.IN_VALID = 0;
        ib.FIFO_FULL = 0; ib.OVF_CLR = 0;
        #12;
        chk("rst_ready", ia.IN_READY, 1);
        chk("rst_busy", ia.BUSY, 0);
        chk("rst_inc", ia.WR_INC, 0);
        chk("rst_data", ia.WR_DATA, 0);
        chk("rst_ovf", ia.OVERFLOW, 0);
        chk("rst_cnt", ia.BYTE_CNT, 0);
        step();
        rst_n = 1'b1;
        step();

        // narrow word
        push_a(1'b0, 16'h00A5);
        #1;
        chk("nar_c1_inc", ia.WR_INC, 0);
        chk("nar_c1_busy", ia.BUSY, 1);
        step();
        chk("nar_c2_inc", ia.WR_INC, 1);
        chk("nar_c2_data", ia.WR_DATA, 8'hA5);
        step();
        chk("nar_done_inc", ia.WR_INC, 0);
        chk("nar_cnt", ia.BYTE_CNT, 1);
        chk("nar_busy", ia.BUSY, 0);

        // wide word, LSB first
        push_a(1'b1, 16'h1234);
        step();
        chk("wide_b0_inc", ia.WR_INC, 1);
        chk("wide_b0_data", ia.WR_DATA, 8'h34);
        step();
        chk("wide_b1_inc", ia.WR_INC, 1);
        chk("wide_b1_data", ia.WR_DATA, 8'h12);
        step();
        chk("wide_done_inc", ia.WR_INC, 0);
        chk("wide_cnt", ia.BYTE_CNT, 3);
        chk("wide_busy", ia.BUSY, 0);

        // wide and narrow, MSB first
        push_b(1'b1, 16'h1234);
        step();
        chk("msb_b0_inc", ib.WR_INC, 1);
        chk("msb_b0_data", ib.WR_DATA, 8'h12);
        step();
        chk("msb_b1_inc", ib.WR_INC, 1);
        chk("msb_b1_data", ib.WR_DATA, 8'h34);
        step();
        push_b(1'b0, 16'h77A5);
        step();
        chk("msb_nar_inc", ib.WR_INC, 1);
        chk("msb_nar_data", ib.WR_DATA, 8'hA5);
        step();
        chk("msb_cnt", ib.BYTE_CNT, 3);
        chk("msb_busy", ib.BUSY, 0);

        // backpressure after first byte
        push_a(1'b1, 16'hBEEF);
        step();
        chk("bp_b0_data", ia.WR_DATA, 8'hEF);
        chk("bp_b0_inc", ia.WR_INC, 1);
        step();
        ia.FIFO_FULL = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_inc", ia.WR_INC, 0);
            chk("bp_hold_data", ia.WR_DATA, 8'hBE);
            step();
        end
        ia.FIFO_FULL = 1'b0;
        #1;
        chk("bp_rel_inc", ia.WR_INC, 1);
        chk("bp_rel_data", ia.WR_DATA, 8'hBE);
        step();
        chk("bp_done_inc", ia.WR_INC, 0);
        chk("bp_cnt", ia.BYTE_CNT, 5);

        // fill queue with FIFO full, then overflow
        ia.FIFO_FULL = 1'b1;
        push_a(1'b0, 16'h0011);
        push_a(1'b1, 16'h2233);
        push_a(1'b0, 16'h0044);
        push_a(1'b1, 16'h5566);
        chk("fill_ready_pre", ia.IN_READY, 1);
        push_a(1'b0, 16'h0077);
        chk("fill_ready", ia.IN_READY, 0);
        chk("fill_ovf_pre", ia.OVERFLOW, 0);
        push_a(1'b0, 16'h0099);
        chk("ovf_set", ia.OVERFLOW, 1);
        chk("ovf_ready", ia.IN_READY, 0);
        ia.FIFO_FULL = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ia.WR_INC) got.push_back(ia.WR_DATA);
            step();
        end
        chk("drain_len", got.size(), 7);
        for (int i = 0; i < 7; i++) begin
            g = (i < got.size()) ? got[i] : 8'h00;
            chk("drain_byte", g, exp_b[i]);
        end
        chk("drain_cnt", ia.BYTE_CNT, 12);
        chk("drain_busy", ia.BUSY, 0);
        ia.OVF_CLR = 1'b1;
        step();
        ia.OVF_CLR = 1'b0;
        chk("ovf_clr", ia.OVERFLOW, 0);

        // reset in BYTE1 with two words queued
        push_a(1'b1, 16'hAABB);
        push_a(1'b1, 16'hCCDD);
        push_a(1'b1, 16'hEEFF);
        chk("mid_inc", ia.WR_INC, 1);
        chk("mid_data", ia.WR_DATA, 8'hAA);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_inc", ia.WR_INC, 0);
        chk("mid_rst_cnt", ia.BYTE_CNT, 0);
        chk("mid_rst_ready", ia.IN_READY, 1);
        chk("mid_rst_busy", ia.BUSY, 0);
        step();
        rst_n = 1'b1;
        incs = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ia.WR_INC) incs++;
            step();
        end
        chk("post_rst_incs", incs, 0);
        chk("post_rst_cnt", ia.BYTE_CNT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
